// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, single-outstanding imem request, one-entry decode buffer.
// Optional perf counters are built when FETCH_PERF_EN is defined.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 32
) (
  input  logic              CLK,
  input  logic              RST,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [31:0]       imem_rsp_data,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [31:0]       instr_out,
  output logic [ADDR_W-1:0] instr_pc,
  output logic [5:0]        Opcode,
  input  logic              redir_valid,
  input  logic [ADDR_W-1:0] redir_pc,
  input  logic [31:0]       redir_instr,
  input  logic              Branch,
  input  logic              Jump,
  input  logic              Zero
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_killed
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pc_inf_q, pc_inf_d;
  logic              kill_q, kill_d;
  logic              req_valid_q, req_valid_d;
  logic              ivalid_q, ivalid_d;
  logic [31:0]       iout_q, iout_d;
  logic [ADDR_W-1:0] ipc_q, ipc_d;

  logic              taken;
  logic [ADDR_W-1:0] p4;
  logic [ADDR_W-1:0] br_off;
  logic [ADDR_W-1:0] target;
  logic [5:0]        unused_op;

  assign unused_op = redir_instr[31:26];

  assign taken  = redir_valid & (Jump | (Branch & Zero));
  assign p4     = redir_pc + 32'd4;
  assign br_off = {{14{redir_instr[15]}}, redir_instr[15:0], 2'b00};
  assign target = Jump
                ? {p4[ADDR_W-1:ADDR_W-4], redir_instr[25:0], 2'b00}
                : p4 + br_off;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    pc_inf_d = pc_inf_q;
    kill_d   = kill_q;
    ivalid_d = ivalid_q;
    iout_d   = iout_q;
    ipc_d    = ipc_q;

    unique case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (imem_req_ready) begin
          state_d  = WAIT;
          pc_inf_d = pc_q;
          pc_d     = pc_q + 32'd4;
        end
      end
      WAIT: begin
        if (imem_rsp_valid) begin
          if (kill_q) begin
            kill_d  = 1'b0;
            state_d = REQ;
          end else begin
            iout_d   = imem_rsp_data;
            ipc_d    = pc_inf_q;
            ivalid_d = 1'b1;
            state_d  = HOLD;
          end
        end
      end
      HOLD: begin
        if (instr_ready) begin
          ivalid_d = 1'b0;
          state_d  = REQ;
        end
      end
      default: state_d = IDLE;
    endcase

    // A taken redirect overrides everything computed above.
    if (taken) begin
      pc_d     = target;
      ivalid_d = 1'b0;
      iout_d   = iout_q;
      ipc_d    = ipc_q;
      unique case (state_q)
        REQ: begin
          if (imem_req_ready) begin
            state_d  = WAIT;
            pc_inf_d = pc_q;
            kill_d   = 1'b1;
          end else begin
            state_d = REQ;
          end
        end
        WAIT: begin
          if (imem_rsp_valid) begin
            kill_d  = 1'b0;
            state_d = REQ;
          end else begin
            kill_d  = 1'b1;
            state_d = WAIT;
          end
        end
        default: state_d = REQ;
      endcase
    end

    req_valid_d = (state_d == REQ);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      pc_inf_q    <= '0;
      kill_q      <= 1'b0;
      req_valid_q <= 1'b0;
      ivalid_q    <= 1'b0;
      iout_q      <= '0;
      ipc_q       <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      pc_inf_q    <= pc_inf_d;
      kill_q      <= kill_d;
      req_valid_q <= req_valid_d;
      ivalid_q    <= ivalid_d;
      iout_q      <= iout_d;
      ipc_q       <= ipc_d;
    end
  end

  assign imem_req_valid = req_valid_q;
  assign imem_req_addr  = pc_q;
  assign instr_valid    = ivalid_q;
  assign instr_out      = iout_q;
  assign instr_pc       = ipc_q;
  assign Opcode         = iout_q[31:26];

`ifdef FETCH_PERF_EN
  logic [31:0] fetched_q, fetched_d;
  logic [31:0] killed_q, killed_d;
  logic        drop_rsp;
  logic        flush_buf;

  // A response is dropped if it was already killed or is killed this cycle.
  assign drop_rsp  = (state_q == WAIT) & imem_rsp_valid & (kill_q | taken);
  assign flush_buf = taken & ivalid_q;

  always_comb begin
    fetched_d = fetched_q;
    killed_d  = killed_q;
    if (ivalid_q & instr_ready & ~taken)
      fetched_d = fetched_q + 32'd1;
    if (drop_rsp | flush_buf)
      killed_d = killed_q + 32'd1;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      fetched_q <= '0;
      killed_q  <= '0;
    end else begin
      fetched_q <= fetched_d;
      killed_q  <= killed_d;
    end
  end

  assign perf_fetched = fetched_q;
  assign perf_killed  = killed_q;
`else
  // Counters are not built.
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: sequential fetch, decode stall,
// jump/branch redirects, killed responses and async reset.
module tb_fetch_unit;

  logic        CLK;
  logic        RST;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_out;
  logic [31:0] instr_pc;
  logic [5:0]  Opcode;
  logic        redir_valid;
  logic [31:0] redir_pc;
  logic [31:0] redir_instr;
  logic        Branch;
  logic        Jump;
  logic        Zero;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_killed;
`endif

  int n_chk;
  int n_fail;

  fetch_unit #(
    .RESET_PC(32'h0000_0000),
    .ADDR_W  (32)
  ) dut (
    .CLK           (CLK),
    .RST           (RST),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr (imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr_out     (instr_out),
    .instr_pc      (instr_pc),
    .Opcode        (Opcode),
    .redir_valid   (redir_valid),
    .redir_pc      (redir_pc),
    .redir_instr   (redir_instr),
    .Branch        (Branch),
    .Jump          (Jump),
    .Zero          (Zero)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched  (perf_fetched),
    .perf_killed   (perf_killed)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    n_chk          = 0;
    n_fail         = 0;
    RST            = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    instr_ready    = 1'b0;
    redir_valid    = 1'b0;
    redir_pc       = '0;
    redir_instr    = '0;
    Branch         = 1'b0;
    Jump           = 1'b0;
    Zero           = 1'b0;

    tick();
    chk("rst_req_v", {31'd0, imem_req_valid}, 32'd0);
    chk("rst_ivalid", {31'd0, instr_valid}, 32'd0);
    chk("rst_iout", instr_out, 32'd0);
    chk("rst_ipc", instr_pc, 32'd0);
    chk("rst_opc", {26'd0, Opcode}, 32'd0);

    RST            = 1'b1;
    imem_req_ready = 1'b1;
    instr_ready    = 1'b1;
    tick();
    chk("req0_v", {31'd0, imem_req_valid}, 32'd1);
    chk("req0_a", imem_req_addr, 32'h0);
    tick();
    chk("wait0_v", {31'd0, imem_req_valid}, 32'd0);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h2001_0005;
    tick();
    imem_rsp_valid = 1'b0;
    chk("hold0_v", {31'd0, instr_valid}, 32'd1);
    chk("hold0_i", instr_out, 32'h2001_0005);
    chk("hold0_pc", instr_pc, 32'h0);
    chk("hold0_op", {26'd0, Opcode}, 32'h08);
    tick();
    chk("req1_iv", {31'd0, instr_valid}, 32'd0);
    chk("req1_v", {31'd0, imem_req_valid}, 32'd1);
    chk("req1_a", imem_req_addr, 32'h4);

    // Decode stalls on the second instruction
    tick();
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h8C01_0004;
    instr_ready    = 1'b0;
    tick();
    imem_rsp_valid = 1'b0;
    chk("hold1_i", instr_out, 32'h8C01_0004);
    chk("hold1_pc", instr_pc, 32'h4);
    chk("hold1_op", {26'd0, Opcode}, 32'h23);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_v", {31'd0, instr_valid}, 32'd1);
      chk("stall_i", instr_out, 32'h8C01_0004);
      chk("stall_req", {31'd0, imem_req_valid}, 32'd0);
    end
    instr_ready = 1'b1;
    tick();
    chk("req2_v", {31'd0, imem_req_valid}, 32'd1);
    chk("req2_a", imem_req_addr, 32'h8);
    chk("req2_iv", {31'd0, instr_valid}, 32'd0);

    // Jump while the fetch of 0x8 is outstanding
    tick();
    redir_valid = 1'b1;
    Jump        = 1'b1;
    redir_pc    = 32'h1000_0010;
    redir_instr = 32'h0800_0040;
    tick();
    redir_valid = 1'b0;
    Jump        = 1'b0;
    chk("jw_req_v", {31'd0, imem_req_valid}, 32'd0);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hDEAD_BEEF;
    tick();
    imem_rsp_valid = 1'b0;
    chk("jw_drop_iv", {31'd0, instr_valid}, 32'd0);
    chk("jw_req_v2", {31'd0, imem_req_valid}, 32'd1);
    chk("jw_tgt", imem_req_addr, 32'h1000_0100);
    tick();
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h3C01_1234;
    tick();
    imem_rsp_valid = 1'b0;
    chk("jt_pc", instr_pc, 32'h1000_0100);
    chk("jt_op", {26'd0, Opcode}, 32'h0F);

    // Taken branch in HOLD flushes the buffer despite instr_ready
    redir_valid = 1'b1;
    Branch      = 1'b1;
    Zero        = 1'b1;
    redir_pc    = 32'h0000_0020;
    redir_instr = 32'h1000_FFFE;
    tick();
    chk("br_flush", {31'd0, instr_valid}, 32'd0);
    chk("br_req_v", {31'd0, imem_req_valid}, 32'd1);
    chk("br_tgt", imem_req_addr, 32'h0000_001C);

    // Not-taken branch and a stray response: no effect
    Zero           = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h5555_5555;
    tick();
    chk("nt_a", imem_req_addr, 32'h0000_001C);
    chk("nt_v", {31'd0, imem_req_valid}, 32'd1);
    chk("nt_iv", {31'd0, instr_valid}, 32'd0);
    redir_valid    = 1'b0;
    Branch         = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_req_ready = 1'b1;
    tick();
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hAC02_0008;
    tick();
    imem_rsp_valid = 1'b0;
    chk("seq_pc", instr_pc, 32'h0000_001C);
    chk("seq_op", {26'd0, Opcode}, 32'h2B);
    tick();
    chk("seq_a", imem_req_addr, 32'h0000_0020);

    // Redirect in REQ without ready retargets the request
    imem_req_ready = 1'b0;
    redir_valid    = 1'b1;
    Jump           = 1'b1;
    redir_pc       = 32'h0;
    redir_instr    = 32'h0800_0100;
    tick();
    chk("rq_v", {31'd0, imem_req_valid}, 32'd1);
    chk("rq_a", imem_req_addr, 32'h0000_0400);

    // Redirect in the cycle the request is accepted
    imem_req_ready = 1'b1;
    redir_instr    = 32'h0800_0200;
    tick();
    redir_valid = 1'b0;
    Jump        = 1'b0;
    chk("ra_v", {31'd0, imem_req_valid}, 32'd0);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h1111_1111;
    tick();
    imem_rsp_valid = 1'b0;
    chk("ra_iv", {31'd0, instr_valid}, 32'd0);
    chk("ra_iout", instr_out, 32'hAC02_0008);
    chk("ra_req_v", {31'd0, imem_req_valid}, 32'd1);
    chk("ra_tgt", imem_req_addr, 32'h0000_0800);
`ifdef FETCH_PERF_EN
    chk("perf_fetched", perf_fetched, 32'd3);
    chk("perf_killed", perf_killed, 32'd3);
`endif

    // Async reset with a request outstanding
    tick();
    chk("pre_rst_v", {31'd0, imem_req_valid}, 32'd0);
    #1;
    RST = 1'b0;
    #1;
    chk("ar_req_v", {31'd0, imem_req_valid}, 32'd0);
    chk("ar_ivalid", {31'd0, instr_valid}, 32'd0);
    chk("ar_iout", instr_out, 32'd0);
    chk("ar_ipc", instr_pc, 32'd0);
    chk("ar_opc", {26'd0, Opcode}, 32'd0);
    chk("ar_addr", imem_req_addr, 32'd0);
`ifdef FETCH_PERF_EN
    chk("ar_perf_k", perf_killed, 32'd0);
`endif
    #1;
    RST = 1'b1;
    tick();
    chk("post_rst_v", {31'd0, imem_req_valid}, 32'd1);
    chk("post_rst_a", imem_req_addr, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
